// File: rtl/dds_wave_gen.sv
// DDS waveform generator: phase accumulator plus registered shaper.
// Optional amplitude scaling stage enabled by DDS_WAVE_AMP_EN.
module dds_wave_gen #(
    parameter int PHASE_W = 32,
    parameter int OUT_W   = 16,
    parameter int DUTY_W  = 8
) (
    input  logic               CLK,
    input  logic               RESET_N,
    input  logic               EN,
    input  logic [PHASE_W-1:0] FTW,
    input  logic               SYNC,
    input  logic [2:0]         FORM,
    input  logic [DUTY_W-1:0]  DUTY,
`ifdef DDS_WAVE_AMP_EN
    input  logic [OUT_W-1:0]   AMP,
`endif
    output logic [OUT_W-1:0]   WAVE,
    output logic               WAVE_VALID,
    output logic               WRAP,
    output logic [2:0]         FORM_ACT
);

    localparam logic [OUT_W-1:0]  MAX_V  = '1;
    localparam logic [OUT_W-1:0]  MID_V  = {1'b1, {(OUT_W-1){1'b0}}};
    localparam logic [DUTY_W-1:0] DUTY_R = {1'b1, {(DUTY_W-1){1'b0}}};

    logic [PHASE_W-1:0] acc;
    logic [DUTY_W-1:0]  duty_act;
    logic               en_q;
    logic [PHASE_W:0]   sum;
    logic               bnd;

    assign sum = {1'b0, acc} + {1'b0, FTW};
    assign bnd = SYNC | (EN & sum[PHASE_W]);

    // Form/duty are captured only on a boundary so mode switches stay glitch-free
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            acc      <= '0;
            WRAP     <= 1'b0;
            FORM_ACT <= 3'b000;
            duty_act <= DUTY_R;
            en_q     <= 1'b0;
        end else begin
            if (SYNC) begin
                acc <= '0;
            end else if (EN) begin
                acc <= sum[PHASE_W-1:0];
            end
            WRAP <= bnd;
            if (bnd) begin
                FORM_ACT <= FORM;
                duty_act <= DUTY;
            end
            en_q <= EN;
        end
    end

    logic [OUT_W-1:0]  p;
    logic [DUTY_W-1:0] d;
    logic [OUT_W-1:0]  t;
    logic [OUT_W-1:0]  shaped;

    assign p = acc[PHASE_W-1 -: OUT_W];
    assign d = acc[PHASE_W-1 -: DUTY_W];
    assign t = {p[OUT_W-2:0], 1'b0};

    always_comb begin
        shaped = MID_V;
        case (FORM_ACT)
            3'b000: shaped = p;
            3'b001: shaped = MAX_V - p;
            3'b010: shaped = p[OUT_W-1] ? (MAX_V - t) : t;
            3'b011: shaped = p[OUT_W-1] ? '0 : MAX_V;
            3'b100: shaped = (d < duty_act) ? MAX_V : '0;
            default: shaped = MID_V;
        endcase
    end

`ifdef DDS_WAVE_AMP_EN
    logic [OUT_W-1:0]   shaped_q;
    logic               en_q2;
    logic [2*OUT_W-1:0] prod;

    assign prod = shaped_q * AMP;

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            shaped_q   <= '0;
            en_q2      <= 1'b0;
            WAVE       <= '0;
            WAVE_VALID <= 1'b0;
        end else begin
            shaped_q   <= shaped;
            en_q2      <= en_q;
            WAVE       <= prod[2*OUT_W-1 -: OUT_W];
            WAVE_VALID <= en_q2;
        end
    end
`else
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            WAVE       <= '0;
            WAVE_VALID <= 1'b0;
        end else begin
            WAVE       <= shaped;
            WAVE_VALID <= en_q;
        end
    end
`endif

endmodule

// File: tb/tb_dds_wave_gen.sv
// Self-checking bench for dds_wave_gen (8-bit phase/output/duty).
// Follows DDS_WAVE_AMP_EN if defined for the build.
module tb_dds_wave_gen;

`ifdef DDS_WAVE_AMP_EN
    localparam bit AMP_ON = 1'b1;
    localparam int LAT    = 3;
`else
    localparam bit AMP_ON = 1'b0;
    localparam int LAT    = 2;
`endif

    logic       CLK = 1'b0;
    logic       RESET_N;
    logic       EN;
    logic [7:0] FTW;
    logic       SYNC;
    logic [2:0] FORM;
    logic [7:0] DUTY;
    logic [7:0] AMP;
    logic [7:0] WAVE;
    logic       WAVE_VALID;
    logic       WRAP;
    logic [2:0] FORM_ACT;

    always #5 CLK = ~CLK;

    dds_wave_gen #(.PHASE_W(8), .OUT_W(8), .DUTY_W(8)) dut (
        .CLK(CLK),
        .RESET_N(RESET_N),
        .EN(EN),
        .FTW(FTW),
        .SYNC(SYNC),
        .FORM(FORM),
        .DUTY(DUTY),
`ifdef DDS_WAVE_AMP_EN
        .AMP(AMP),
`endif
        .WAVE(WAVE),
        .WAVE_VALID(WAVE_VALID),
        .WRAP(WRAP),
        .FORM_ACT(FORM_ACT)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state (plain integers)
    int m_acc, m_form, m_duty, m_wrap, m_wave, m_sh, m_v;
    int en_hist[3];

    task automatic check(input string nm, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0d expected %0d", nm, $time, got, exp);
        end
    endtask

    function automatic int shape(input int a, input int f, input int du);
        case (f)
            0: return a;
            1: return 255 - a;
            2: return (a < 128) ? 2 * a : 255 - 2 * (a - 128);
            3: return (a < 128) ? 255 : 0;
            4: return (a < du) ? 255 : 0;
            default: return 128;
        endcase
    endfunction

    function automatic int scale(input int x);
        if (AMP_ON) return (x * int'(AMP)) / 256;
        return x;
    endfunction

    task automatic model_reset();
        m_acc = 0; m_form = 0; m_duty = 128; m_wrap = 0;
        m_wave = 0; m_sh = 0; m_v = 0;
        for (int i = 0; i < 3; i++) en_hist[i] = 0;
    endtask

    // One clock: predict, advance, compare at the falling edge
    task automatic cycle();
        int s, sum, nacc, b;
        s    = shape(m_acc, m_form, m_duty);
        sum  = m_acc + int'(FTW);
        b    = (SYNC || (EN && sum >= 256)) ? 1 : 0;
        nacc = SYNC ? 0 : (EN ? sum % 256 : m_acc);
        if (AMP_ON) begin
            m_wave = scale(m_sh);
            m_sh   = s;
        end else begin
            m_wave = s;
        end
        m_v = en_hist[LAT-2];
        for (int i = 2; i > 0; i--) en_hist[i] = en_hist[i-1];
        en_hist[0] = int'(EN);
        m_acc  = nacc;
        m_wrap = b;
        if (b != 0) begin
            m_form = int'(FORM);
            m_duty = int'(DUTY);
        end
        @(posedge CLK);
        @(negedge CLK);
        check("wave", int'(WAVE), m_wave);
        check("valid", int'(WAVE_VALID), m_v);
        check("wrap", int'(WRAP), m_wrap);
        check("form_act", int'(FORM_ACT), m_form);
    endtask

    typedef struct {
        logic [2:0] form;
        logic [7:0] duty;
        logic [7:0] acc;
        int         exp;
    } vec_t;

    vec_t vecs[14];

    initial begin
        int cnt, wraps;
        vecs[0]  = '{3'd2, 8'd0,  8'd0,   0};
        vecs[1]  = '{3'd2, 8'd0,  8'd1,   2};
        vecs[2]  = '{3'd2, 8'd0,  8'd127, 254};
        vecs[3]  = '{3'd2, 8'd0,  8'd128, 255};
        vecs[4]  = '{3'd2, 8'd0,  8'd255, 1};
        vecs[5]  = '{3'd4, 8'd64, 8'd63,  255};
        vecs[6]  = '{3'd4, 8'd64, 8'd64,  0};
        vecs[7]  = '{3'd4, 8'd0,  8'd0,   0};
        vecs[8]  = '{3'd1, 8'd0,  8'd100, 155};
        vecs[9]  = '{3'd3, 8'd0,  8'd127, 255};
        vecs[10] = '{3'd3, 8'd0,  8'd128, 0};
        vecs[11] = '{3'd5, 8'd0,  8'd10,  128};
        vecs[12] = '{3'd7, 8'd0,  8'd200, 128};
        vecs[13] = '{3'd0, 8'd0,  8'd200, 200};

        RESET_N = 1'b0; EN = 1'b0; FTW = 8'd0; SYNC = 1'b0;
        FORM = 3'd0; DUTY = 8'd0; AMP = 8'd128;
        model_reset();
        @(negedge CLK); @(negedge CLK);
        check("rst_wave", int'(WAVE), 0);
        check("rst_valid", int'(WAVE_VALID), 0);
        check("rst_wrap", int'(WRAP), 0);
        check("rst_form", int'(FORM_ACT), 0);
        RESET_N = 1'b1;
        repeat (3) cycle();

        // WAVE_VALID rises LAT cycles after EN
        EN = 1'b1; FTW = 8'd1;
        cnt = 0;
        while (cnt < 10) begin
            cycle();
            cnt++;
            if (WAVE_VALID) break;
        end
        check("valid_latency", cnt, LAT);

        // Saw over a full period: exactly one wrap
        SYNC = 1'b1; cycle(); SYNC = 1'b0;
        wraps = 0;
        for (int i = 0; i < 256; i++) begin
            cycle();
            if (WRAP) wraps++;
        end
        check("saw_wraps", wraps, 1);

        // Deferred form change at acc=100
        SYNC = 1'b1; FORM = 3'd0; cycle(); SYNC = 1'b0;
        repeat (100) cycle();
        FORM = 3'd1;
        cycle();
        check("defer_hold", int'(FORM_ACT), 0);
        cnt = 0;
        while (!WRAP && cnt < 300) begin
            cycle();
            cnt++;
        end
        check("defer_wrap_seen", int'(WRAP), 1);
        check("defer_form", int'(FORM_ACT), 1);
        repeat (LAT - 1) cycle();
        check("defer_first", int'(WAVE), scale(255));
        cycle();
        check("defer_second", int'(WAVE), scale(254));

        // SYNC at acc=77 applies a pending form
        SYNC = 1'b1; FORM = 3'd0; cycle(); SYNC = 1'b0;
        repeat (77) cycle();
        FORM = 3'd3; SYNC = 1'b1;
        cycle();
        SYNC = 1'b0;
        check("sync77_wrap", int'(WRAP), 1);
        check("sync77_form", int'(FORM_ACT), 3);

        // SYNC coinciding with carry: single pulse
        repeat (255) cycle();
        SYNC = 1'b1; cycle(); SYNC = 1'b0;
        check("sync_carry_wrap", int'(WRAP), 1);
        cycle();
        check("sync_carry_once", int'(WRAP), 0);

        // FTW=0: no boundary, pending form never applies
        FTW = 8'd0; FORM = 3'd2; wraps = 0;
        for (int i = 0; i < 300; i++) begin
            cycle();
            if (WRAP) wraps++;
        end
        check("ftw0_wraps", wraps, 0);
        check("ftw0_form", int'(FORM_ACT), 3);

        // Shaper table
        foreach (vecs[i]) begin
            FORM = vecs[i].form; DUTY = vecs[i].duty;
            SYNC = 1'b1; EN = 1'b0; cycle();
            SYNC = 1'b0; EN = 1'b1; FTW = vecs[i].acc; cycle();
            EN = 1'b0; FTW = 8'd0;
            repeat (3) cycle();
            check($sformatf("table%0d", i), int'(WAVE), scale(vecs[i].exp));
        end

        // Pulse duty 64: 64 high samples per period
        FORM = 3'd4; DUTY = 8'd64; FTW = 8'd1; EN = 1'b1;
        SYNC = 1'b1; cycle(); SYNC = 1'b0;
        repeat (LAT) cycle();
        cnt = 0;
        for (int i = 0; i < 256; i++) begin
            cycle();
            if (WAVE == 8'(scale(255))) cnt++;
        end
        check("pulse_high_count", cnt, 64);

        // Asynchronous reset mid-period
        FORM = 3'd1; SYNC = 1'b1; cycle(); SYNC = 1'b0;
        repeat (40) cycle();
        #2 RESET_N = 1'b0;
        #1;
        check("arst_wave", int'(WAVE), 0);
        check("arst_valid", int'(WAVE_VALID), 0);
        check("arst_form", int'(FORM_ACT), 0);
        check("arst_wrap", int'(WRAP), 0);
        @(negedge CLK);
        RESET_N = 1'b1;
        model_reset();
        repeat (4) cycle();

        // Randomized run against the model
        for (int i = 0; i < 3000; i++) begin
            EN   = ($urandom % 4) != 0;
            FTW  = ($urandom % 2) != 0 ? 8'($urandom_range(0, 8)) : 8'($urandom);
            SYNC = ($urandom % 32) == 0;
            FORM = 3'($urandom);
            DUTY = 8'($urandom);
            AMP  = 8'($urandom);
            cycle();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/dds_wave_gen.md
# dds_wave_gen

Parametrised DDS waveform generator: an internal phase accumulator driven by a frequency tuning word, followed by a registered waveform shaper. It produces saw, reverse saw, triangle, square, and programmable-duty pulse outputs. Form and duty changes take effect only at a period boundary, so mode switches are glitch-free. It sits between the control register file and the DAC output path and replaces the fixed 8-bit single-stage shaper.

## Interface
Parameters:
- PHASE_W, 32: phase accumulator width; must be ≥ OUT_W and ≥ DUTY_W.
- OUT_W, 16: output sample width, unsigned offset-binary.
- DUTY_W, 8: duty-cycle control width.

Ports:
- CLK  in  1  single clock; all state on rising edge.
- RESET_N  in  1  asynchronous, active-low reset.
- EN  in  1  accumulate enable; low freezes phase.
- FTW  in  PHASE_W  frequency tuning word (phase increment per cycle).
- SYNC  in  1  phase restart; forces accumulator to 0.
- FORM  in  3  requested waveform form.
- DUTY  in  DUTY_W  requested pulse duty (form 100).
- AMP  in  OUT_W  amplitude scale; present only with DDS_WAVE_AMP_EN.
- WAVE  out  OUT_W  shaped sample.
- WAVE_VALID  out  1  WAVE corresponds to an enabled phase step.
- WRAP  out  1  one-cycle pulse at period boundary.
- FORM_ACT  out  3  currently applied form.

## Operation
- Accumulator acc: SYNC=1 → acc←0 (priority over EN). Otherwise EN=1 → acc←(acc+FTW) mod 2^PHASE_W. Otherwise hold.
- Boundary event B = SYNC, or (EN and carry out of acc+FTW). WRAP register ← B.
- FORM and DUTY are sampled every cycle, but form_act/duty_act load only on B. FTW applies immediately.
- p = acc[PHASE_W-1 -: OUT_W]; d = acc[PHASE_W-1 -: DUTY_W]; MAX = 2^OUT_W−1.
- Form 000 saw: p.
- Form 001 reverse saw: MAX−p.
- Form 010 triangle: let t = {p[OUT_W-2:0],0}. Output is t when p[OUT_W-1]=0, else MAX−t.
- Form 011 square: MAX when p[OUT_W-1]=0, else 0.
- Form 100 pulse: MAX when d < duty_act, else 0. duty_act=0 gives constant 0.
- Forms 101–111: midscale 2^(OUT_W-1), constant.
- All arithmetic is unsigned and modulo its width. There is no saturation except as stated.
- Boundary conditions:
  - FTW=0 with SYNC low: no B ever occurs, and pending FORM/DUTY never apply.
  - SYNC coinciding with a carry: exactly one WRAP pulse.
  - FORM changing on the same cycle as B: the new value is loaded.
  - RESET_N low mid-run: all state clears immediately, without a clock edge.

## Timing
- Reset values:
  - acc=0
  - WAVE=0
  - WAVE_VALID=0
  - WRAP=0
  - FORM_ACT=000
  - duty_act=2^(DUTY_W-1)
- Latency: acc updates at edge N; WAVE shows the shape of that acc, using the form_act in effect with it, at edge N+1.
- The shaper pipeline carries form_act/duty_act alongside acc, so the first sample after B uses the new form.
- WRAP asserts at the same edge as acc←new value. FORM_ACT updates at that edge.
- WAVE_VALID is EN delayed by the pipeline depth: 2 cycles, or 3 with DDS_WAVE_AMP_EN.
- WAVE_VALID is 0 for the first 2 (3) edges after reset release.
- The shaper runs every cycle irrespective of EN. With EN low, WAVE holds the value for the frozen acc.

## Configuration
- DDS_WAVE_AMP_EN defined:
  - Adds the AMP port and one extra pipeline register.
  - WAVE = (shaped × AMP) >> OUT_W, with the full 2·OUT_W product truncated.
  - Midscale forms are also scaled.
  - Latency becomes 3.
- Not defined:
  - No AMP port and no multiplier.
  - WAVE = shaped.
  - Latency 2.

## Test plan
All cases use PHASE_W=OUT_W=DUTY_W=8 unless stated.
- Saw: FORM=000, FTW=1, EN=1 → WAVE steps 0,1,…,255,0. WRAP pulses once every 256 cycles, in the cycle acc=0. WAVE_VALID rises 2 cycles after EN.
- Triangle: FORM=010, FTW=1 → samples at p=0,1,127,128,255 are 0,2,254,255,1.
- Pulse: FORM=100, DUTY=64 → 64 cycles at 255, then 192 cycles at 0, per period. DUTY=0 → constant 0.
- Deferred mode change: saw running, FORM←001 at acc=100.
  - Saw continues to 255.
  - WRAP asserts, FORM_ACT=001.
  - First new sample is 255 (acc=0), then 254,…
- SYNC and reset:
  - SYNC at acc=77 → acc=0 next edge, WRAP=1, pending FORM applied. SYNC together with the natural carry → single WRAP.
  - RESET_N low asynchronously mid-period → WAVE=0, WAVE_VALID=0, FORM_ACT=000 before the next CLK edge.
- DDS_WAVE_AMP_EN: FORM=011, AMP=128 → WAVE alternates 127/0, latency 3. FORM=101 with AMP=128 → 64.
